// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, ALU opcodes and the reservation-station entry layout.
package alu_rs_pkg;
    localparam int TAG_W = 4;
    localparam int OP_W  = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BGE  = 5'd12,
        ALU_BGEU = 5'd13,
        ALU_BLT  = 5'd14,
        ALU_BLTU = 5'd15,
        ALU_MUL  = 5'd16
    } alu_op_e;

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [31:0]      vj;
        logic [TAG_W-1:0] qj;
        logic             qj_busy;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qk;
        logic             qk_busy;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

    function automatic logic cdb_hit(input logic done, input logic [TAG_W-1:0] cdb_tag, input logic [TAG_W-1:0] q);
        return done && cdb_tag == q;
    endfunction
endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch issue port, both CDB snoop ports and the ALU-side issue port.
interface alu_rs_if;
    import alu_rs_pkg::*;
    logic             issue_valid;
    logic [OP_W-1:0]  issue_op;
    logic [31:0]      issue_vj;
    logic [TAG_W-1:0] issue_qj;
    logic             issue_qj_busy;
    logic [31:0]      issue_vk;
    logic [TAG_W-1:0] issue_qk;
    logic             issue_qk_busy;
    logic [TAG_W-1:0] issue_dest;
    logic             rs_full;
    logic             cdb_alu_done;
    logic [TAG_W-1:0] cdb_alu_tag;
    logic [31:0]      cdb_alu_data;
    logic             cdb_lsb_done;
    logic [TAG_W-1:0] cdb_lsb_tag;
    logic [31:0]      cdb_lsb_data;
    logic             alu_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [OP_W-1:0]  alu_op;
    logic [TAG_W-1:0] tag;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_qj_busy,
               issue_vk, issue_qk, issue_qk_busy, issue_dest,
               cdb_alu_done, cdb_alu_tag, cdb_alu_data,
               cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data,
        input  rs_full, alu_ready, a, b, alu_op, tag
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_qj_busy,
               issue_vk, issue_qk, issue_qk_busy, issue_dest,
               cdb_alu_done, cdb_alu_tag, cdb_alu_data,
               cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data,
        output rs_full, alu_ready, a, b, alu_op, tag
    );
endinterface

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-index set bit of req, with a found flag.
module rs_prio_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; holds ops until operands arrive on a CDB,
// then issues the lowest-index ready entry to the ALU, one per cycle.
module alu_rs import alu_rs_pkg::*; #(
    parameter int RS_SIZE = 8
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    input logic        flush,
    alu_rs_if.slave    io
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_v;
    logic [RS_SIZE-1:0] ready_v;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      pick_idx;
    logic               free_found;
    logic               pick_found;
    logic               do_issue;
    logic               go;
    logic               fj_a, fj_l, fk_a, fk_l;
    rs_entry_t          new_e;
    logic [31:0]        vj_a [RS_SIZE];
    logic [31:0]        vk_a [RS_SIZE];
    logic [OP_W-1:0]    op_a [RS_SIZE];
    logic [TAG_W-1:0]   dest_a [RS_SIZE];

    rs_prio_enc #(.N(RS_SIZE)) u_free (.req(~busy_v), .idx(free_idx), .found(free_found));
    rs_prio_enc #(.N(RS_SIZE)) u_pick (.req(ready_v), .idx(pick_idx), .found(pick_found));

    assign io.rs_full = ~free_found;
    assign do_issue   = io.issue_valid && free_found;
    assign go         = pick_found && !flush;

    // Operands produced on a CDB in the issue cycle are captured directly.
    always_comb begin
        fj_a  = io.issue_qj_busy && cdb_hit(io.cdb_alu_done, io.cdb_alu_tag, io.issue_qj);
        fj_l  = io.issue_qj_busy && cdb_hit(io.cdb_lsb_done, io.cdb_lsb_tag, io.issue_qj);
        fk_a  = io.issue_qk_busy && cdb_hit(io.cdb_alu_done, io.cdb_alu_tag, io.issue_qk);
        fk_l  = io.issue_qk_busy && cdb_hit(io.cdb_lsb_done, io.cdb_lsb_tag, io.issue_qk);
        new_e = '{
            busy:    1'b1,
            op:      io.issue_op,
            vj:      fj_a ? io.cdb_alu_data : fj_l ? io.cdb_lsb_data : io.issue_vj,
            qj:      io.issue_qj,
            qj_busy: io.issue_qj_busy && !fj_a && !fj_l,
            vk:      fk_a ? io.cdb_alu_data : fk_l ? io.cdb_lsb_data : io.issue_vk,
            qk:      io.issue_qk,
            qk_busy: io.issue_qk_busy && !fk_a && !fk_l,
            dest:    io.issue_dest
        };
    end

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
        rs_entry_t e;
        logic      wj_a, wj_l, wk_a, wk_l;
        assign wj_a       = cdb_hit(io.cdb_alu_done, io.cdb_alu_tag, e.qj);
        assign wj_l       = cdb_hit(io.cdb_lsb_done, io.cdb_lsb_tag, e.qj);
        assign wk_a       = cdb_hit(io.cdb_alu_done, io.cdb_alu_tag, e.qk);
        assign wk_l       = cdb_hit(io.cdb_lsb_done, io.cdb_lsb_tag, e.qk);
        assign busy_v[i]  = e.busy;
        assign ready_v[i] = e.busy && !e.qj_busy && !e.qk_busy;
        assign vj_a[i]    = e.vj;
        assign vk_a[i]    = e.vk;
        assign op_a[i]    = e.op;
        assign dest_a[i]  = e.dest;
        // Payload is left unreset; only busy gates its use.
        always_ff @(posedge clk) begin
            if (rst) begin
                e.busy <= 1'b0;
            end else if (rdy) begin
                if (flush) begin
                    e.busy <= 1'b0;
                end else if (do_issue && free_idx == IW'(i)) begin
                    e <= new_e;
                end else begin
                    if (pick_found && pick_idx == IW'(i)) e.busy <= 1'b0;
                    if (e.busy && e.qj_busy && (wj_a || wj_l)) begin
                        e.vj      <= wj_a ? io.cdb_alu_data : io.cdb_lsb_data;
                        e.qj_busy <= 1'b0;
                    end
                    if (e.busy && e.qk_busy && (wk_a || wk_l)) begin
                        e.vk      <= wk_a ? io.cdb_alu_data : io.cdb_lsb_data;
                        e.qk_busy <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io.alu_ready <= 1'b0;
            io.a         <= '0;
            io.b         <= '0;
            io.alu_op    <= ALU_ADD;
            io.tag       <= '0;
        end else if (rdy) begin
            io.alu_ready <= go;
            io.a         <= go ? vj_a[pick_idx] : '0;
            io.b         <= go ? vk_a[pick_idx] : '0;
            io.alu_op    <= go ? op_a[pick_idx] : ALU_ADD;
            io.tag       <= go ? dest_a[pick_idx] : '0;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs; expected ALU issues are queued at stimulus
// time and compared in order whenever the station presents one.
module tb_alu_rs;
    import alu_rs_pkg::*;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;
    logic rdy_q;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_rs_if bus();

    alu_rs #(.RS_SIZE(8)) dut (.clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io(bus));

    always #5 clk = ~clk;

    always @(posedge clk) rdy_q <= rdy;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // A beat counts as a new issue only if the station was enabled at that edge.
    always @(negedge clk) begin
        if (!rst && bus.alu_ready === 1'b1 && rdy_q === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(bus.alu_ready), 64'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("sb_a", 64'(bus.a), 64'(x.a));
                check("sb_b", 64'(bus.b), 64'(x.b));
                check("sb_op", 64'(bus.alu_op), 64'(x.op));
                check("sb_tag", 64'(bus.tag), 64'(x.tag));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid  = 1'b0;
        bus.cdb_alu_done = 1'b0;
        bus.cdb_lsb_done = 1'b0;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                         input logic qjb, input logic qkb, input logic [TAG_W-1:0] dest);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_vk      = vk;
        bus.issue_qj      = qj;
        bus.issue_qk      = qk;
        bus.issue_qj_busy = qjb;
        bus.issue_qk_busy = qkb;
        bus.issue_dest    = dest;
    endtask

    task automatic cdb(input bit lsb, input logic [TAG_W-1:0] t, input logic [31:0] d);
        if (lsb) begin
            bus.cdb_lsb_done = 1'b1;
            bus.cdb_lsb_tag  = t;
            bus.cdb_lsb_data = d;
        end else begin
            bus.cdb_alu_done = 1'b1;
            bus.cdb_alu_tag  = t;
            bus.cdb_alu_data = d;
        end
    endtask

    task automatic expect_issue(input logic [31:0] a, input logic [31:0] b,
                                input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t);
        exp_t x;
        x.a = a;
        x.b = b;
        x.op = op;
        x.tag = t;
        sb.push_back(x);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        issue(ALU_ADD, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        idle();
        bus.cdb_alu_tag = '0;
        bus.cdb_alu_data = '0;
        bus.cdb_lsb_tag = '0;
        bus.cdb_lsb_data = '0;
        repeat (2) step();
        rst = 1'b0;
        check("rst_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_a", 64'(bus.a), 64'd0);
        check("rst_b", 64'(bus.b), 64'd0);
        check("rst_op", 64'(bus.alu_op), 64'd0);
        check("rst_tag", 64'(bus.tag), 64'd0);
        check("rst_full", 64'(bus.rs_full), 64'd0);

        // operands ready at issue
        issue(ALU_ADD, 5, 7, 0, 0, 1'b0, 1'b0, 1);
        expect_issue(5, 7, ALU_ADD, 1);
        step();
        idle();
        check("t1_pre", 64'(bus.alu_ready), 64'd0);
        step();
        check("t1_go", 64'(bus.alu_ready), 64'd1);
        step();
        check("t1_off", 64'(bus.alu_ready), 64'd0);

        // wake-up from ALU CDB
        issue(ALU_SUB, 32'hdead_beef, 2, 3, 0, 1'b1, 1'b0, 2);
        step();
        idle();
        check("t2_wait0", 64'(bus.alu_ready), 64'd0);
        step();
        check("t2_wait1", 64'(bus.alu_ready), 64'd0);
        cdb(1'b0, 3, 10);
        expect_issue(10, 2, ALU_SUB, 2);
        step();
        idle();
        check("t2_wake", 64'(bus.alu_ready), 64'd0);
        step();
        check("t2_go", 64'(bus.alu_ready), 64'd1);
        step();
        check("t2_off", 64'(bus.alu_ready), 64'd0);

        // forwarding from LSB CDB in the issue cycle
        issue(ALU_AND, 1, 0, 0, 6, 1'b0, 1'b1, 3);
        cdb(1'b1, 6, 32'hffff_ffff);
        expect_issue(1, 32'hffff_ffff, ALU_AND, 3);
        step();
        idle();
        check("t3_pre", 64'(bus.alu_ready), 64'd0);
        step();
        check("t3_go", 64'(bus.alu_ready), 64'd1);
        step();

        // fill, drop the overflow issue, drain in index order
        for (int i = 0; i < 8; i++) begin
            check("t4_nfull", 64'(bus.rs_full), 64'd0);
            issue(OP_W'(i), 0, 32'(i), 9, 0, 1'b1, 1'b0, TAG_W'(i));
            step();
        end
        idle();
        check("t4_full", 64'(bus.rs_full), 64'd1);
        issue(ALU_XOR, 0, 32'h77, 9, 0, 1'b1, 1'b0, 15);
        step();
        idle();
        check("t4_full_hold", 64'(bus.rs_full), 64'd1);
        check("t4_idle", 64'(bus.alu_ready), 64'd0);
        cdb(1'b0, 9, 32'h99);
        for (int i = 0; i < 8; i++) expect_issue(32'h99, 32'(i), OP_W'(i), TAG_W'(i));
        step();
        idle();
        check("t4_wake", 64'(bus.alu_ready), 64'd0);
        check("t4_wake_full", 64'(bus.rs_full), 64'd1);
        step();
        check("t4_first", 64'(bus.alu_ready), 64'd1);
        check("t4_unfull", 64'(bus.rs_full), 64'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t4_seq", 64'(bus.alu_ready), 64'd1);
        end
        step();
        check("t4_done", 64'(bus.alu_ready), 64'd0);

        // flush with four ready entries and a concurrent issue
        for (int i = 0; i < 4; i++) begin
            issue(ALU_ADD, 0, 0, 5, 0, 1'b1, 1'b0, TAG_W'(8 + i));
            step();
        end
        idle();
        cdb(1'b0, 5, 1);
        step();
        idle();
        issue(ALU_ADD, 1, 1, 0, 0, 1'b0, 1'b0, 12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("t5_ready", 64'(bus.alu_ready), 64'd0);
        check("t5_full", 64'(bus.rs_full), 64'd0);
        n = 0;
        repeat (6) begin
            step();
            n += int'(bus.alu_ready);
        end
        check("t5_quiet", 64'(n), 64'd0);

        // rdy stall freezes outputs and ignores a broadcast
        issue(ALU_OR, 0, 1, 8, 0, 1'b1, 1'b0, 6);
        step();
        issue(ALU_MUL, 3, 4, 0, 0, 1'b0, 1'b0, 7);
        expect_issue(3, 4, ALU_MUL, 7);
        step();
        issue(ALU_SLT, 9, 10, 0, 0, 1'b0, 1'b0, 5);
        expect_issue(9, 10, ALU_SLT, 5);
        step();
        idle();
        check("t6_pre", 64'(bus.alu_ready), 64'd1);
        rdy = 1'b0;
        cdb(1'b0, 8, 32'h55);
        repeat (3) begin
            step();
            check("t6_hold_ready", 64'(bus.alu_ready), 64'd1);
            check("t6_hold_a", 64'(bus.a), 64'd3);
        end
        rdy = 1'b1;
        idle();
        step();
        check("t6_resume", 64'(bus.alu_ready), 64'd1);
        check("t6_resume_a", 64'(bus.a), 64'd9);
        step();
        check("t6_ignored", 64'(bus.alu_ready), 64'd0);
        cdb(1'b0, 8, 32'h55);
        expect_issue(32'h55, 1, ALU_OR, 6);
        step();
        idle();
        step();
        check("t6_late", 64'(bus.alu_ready), 64'd1);
        repeat (2) step();
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
